// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: converts a valid/ready command stream into pipelined
// single-beat AHB transfers and returns one response pulse per command.
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ahb_hclk,
    input  logic                  ahb_hrstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic [1:0]            ahb_htrans,
    output logic [ADDR_WIDTH-1:0] ahb_haddr,
    output logic                  ahb_hwrite,
    output logic [2:0]            ahb_hsize,
    output logic [2:0]            ahb_hburst,
    output logic [DATA_WIDTH-1:0] ahb_hwdata,
    input  logic                  ahb_hready,
    input  logic                  ahb_hresp,
    input  logic [DATA_WIDTH-1:0] ahb_hrdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic                  ap_valid_q, ap_valid_d;
    logic                  ap_write_q, ap_write_d;
    logic [ADDR_WIDTH-1:0] ap_addr_q,  ap_addr_d;
    logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;
    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic [DATA_WIDTH-1:0] hwdata_q,   hwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic err_first_s;
    logic accept_s;
    logic ap_adv_s;
    logic dp_done_s;

    // Handshake and pipeline-advance qualifiers for the current cycle
    always_comb begin
        err_first_s = dp_valid_q && ahb_hresp && !ahb_hready;
        cmd_ready   = !ap_valid_q || (ahb_hready && !err_first_s);
        accept_s    = cmd_valid && cmd_ready;
        ap_adv_s    = ahb_hready && ap_valid_q;
        dp_done_s   = ahb_hready && dp_valid_q;
    end

    // Next-state for the address-phase, data-phase and response registers
    always_comb begin
        ap_valid_d  = ap_valid_q;
        ap_write_d  = ap_write_q;
        ap_addr_d   = ap_addr_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = dp_done_s;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept_s) begin
            ap_valid_d = 1'b1;
            ap_write_d = cmd_write;
            ap_addr_d  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            ap_wdata_d = cmd_wdata;
        end else if (ap_adv_s) begin
            ap_valid_d = 1'b0;
        end else begin
            ap_valid_d = ap_valid_q;
        end

        // A completing data phase is replaced in the same edge by the advancing address phase
        if (ap_adv_s) begin
            dp_valid_d = 1'b1;
            dp_write_d = ap_write_q;
            hwdata_d   = ap_write_q ? ap_wdata_q : {DATA_WIDTH{1'b0}};
        end else if (dp_done_s) begin
            dp_valid_d = 1'b0;
        end else begin
            dp_valid_d = dp_valid_q;
        end

        if (dp_done_s) begin
            rsp_write_d = dp_write_q;
            rsp_err_d   = ahb_hresp;
            rsp_rdata_d = dp_write_q ? {DATA_WIDTH{1'b0}} : ahb_hrdata;
        end else begin
            rsp_write_d = rsp_write_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge ahb_hclk or negedge ahb_hrstn) begin
        if (!ahb_hrstn) begin
            ap_valid_q  <= 1'b0;
            ap_write_q  <= 1'b0;
            ap_addr_q   <= {ADDR_WIDTH{1'b0}};
            ap_wdata_q  <= {DATA_WIDTH{1'b0}};
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= {DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            ap_valid_q  <= ap_valid_d;
            ap_write_q  <= ap_write_d;
            ap_addr_q   <= ap_addr_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bus outputs; the pending transfer is withdrawn during the first ERROR cycle
    always_comb begin
        if (ap_valid_q && !err_first_s) begin
            ahb_htrans = HTRANS_NONSEQ;
        end else begin
            ahb_htrans = HTRANS_IDLE;
        end
        ahb_haddr  = ap_addr_q;
        ahb_hwrite = ap_write_q;
        ahb_hsize  = 3'b010;
        ahb_hburst = 3'b000;
        ahb_hwdata = hwdata_q;
        rsp_valid  = rsp_valid_q;
        rsp_write  = rsp_write_q;
        rsp_err    = rsp_err_q;
        rsp_rdata  = rsp_rdata_q;
        busy       = ap_valid_q || dp_valid_q;
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master; inputs change after the
// falling edge and outputs are sampled 1ns later.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, hrdata, rsp_rdata;
    logic        hwrite, hready, hresp;
    logic [2:0]  hsize, hburst;
    logic        rsp_valid, rsp_write, rsp_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ahb_hclk(clk), .ahb_hrstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .ahb_htrans(htrans), .ahb_haddr(haddr), .ahb_hwrite(hwrite),
        .ahb_hsize(hsize), .ahb_hburst(hburst), .ahb_hwdata(hwdata),
        .ahb_hready(hready), .ahb_hresp(hresp), .ahb_hrdata(hrdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .busy(busy)
    );

    task automatic cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    endtask

    task automatic slave(input logic rdy, input logic rsp, input logic [31:0] rd);
        hready = rdy; hresp = rsp; hrdata = rd;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %0h exp 0", htrans); end
        checks++; if (haddr !== 32'h0 || hwrite !== 1'b0 || hwdata !== 32'h0) begin errors++; $display("FAIL rst_bus: haddr %0h hwrite %0b hwdata %0h exp 0", haddr, hwrite, hwdata); end
        checks++; if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp: v %0b w %0b e %0b d %0h exp 0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_busy_ready: busy %0b ready %0b exp 0/1", busy, cmd_ready); end
        checks++; if (hsize !== 3'b010 || hburst !== 3'b000) begin errors++; $display("FAIL rst_const: hsize %0h hburst %0h exp 2/0", hsize, hburst); end
    endtask

    task automatic do_single_write(input logic [31:0] a, input logic [31:0] d);
        cmd(1'b1, 1'b1, a, d); #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0b exp 1", cmd_ready); end
        @(negedge clk); cmd(1'b0, 1'b0, 32'h0, 32'h0); #1;
        checks++; if (htrans !== 2'b10 || haddr !== a || hwrite !== 1'b1) begin errors++; $display("FAIL wr_addr_phase: htrans %0h haddr %0h hwrite %0b exp 2 %0h 1", htrans, haddr, hwrite, a); end
        @(negedge clk); #1;
        checks++; if (hwdata !== d || htrans !== 2'b00 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_data_phase: hwdata %0h htrans %0h rsp_valid %0b exp %0h 0 0", hwdata, htrans, rsp_valid, d); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp: v %0b w %0b e %0b d %0h exp 1 1 0 0", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy: got %0b exp 0", busy); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse: got %0b exp 0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_single_write();
        do_single_write(32'h0000_1000, 32'hA5A5_0001);
    endtask

    task automatic test_read_wait();
        cmd(1'b1, 1'b0, 32'h0000_2003, 32'h0);
        @(negedge clk); cmd(1'b0, 1'b0, 32'h0, 32'h0); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h2000 || hwrite !== 1'b0) begin errors++; $display("FAIL rd_addr_phase: htrans %0h haddr %0h hwrite %0b exp 2 2000 0", htrans, haddr, hwrite); end
        @(negedge clk); slave(1'b0, 1'b0, 32'h0); #1;
        checks++; if (htrans !== 2'b00 || busy !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_wait1: htrans %0h busy %0b ready %0b exp 0 1 1", htrans, busy, cmd_ready); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || haddr !== 32'h2000 || htrans !== 2'b00) begin errors++; $display("FAIL rd_wait2: rsp_valid %0b haddr %0h htrans %0h exp 0 2000 0", rsp_valid, haddr, htrans); end
        @(negedge clk); slave(1'b1, 1'b0, 32'hDEAD_BEEF); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_rsp: got %0b exp 0", rsp_valid); end
        @(negedge clk); slave(1'b1, 1'b0, 32'h0); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp: v %0b w %0b e %0b d %0h exp 1 0 0 deadbeef", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        cmd(1'b1, 1'b1, 32'h0, 32'h0000_0011);
        @(negedge clk); cmd(1'b1, 1'b0, 32'h4, 32'h0); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h0 || hwrite !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_c1: htrans %0h haddr %0h hwrite %0b ready %0b exp 2 0 1 1", htrans, haddr, hwrite, cmd_ready); end
        @(negedge clk); cmd(1'b1, 1'b1, 32'h8, 32'h0000_0033); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h4 || hwrite !== 1'b0 || hwdata !== 32'h11 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_c2: htrans %0h haddr %0h hwrite %0b hwdata %0h ready %0b", htrans, haddr, hwrite, hwdata, cmd_ready); end
        @(negedge clk); cmd(1'b1, 1'b0, 32'hC, 32'h0); slave(1'b1, 1'b0, 32'h0000_0044); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h8 || hwdata !== 32'h0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_c3: htrans %0h haddr %0h hwdata %0h ready %0b exp 2 8 0 1", htrans, haddr, hwdata, cmd_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rsp0: v %0b w %0b d %0h exp 1 1 0", rsp_valid, rsp_write, rsp_rdata); end
        @(negedge clk); cmd(1'b0, 1'b0, 32'h0, 32'h0); slave(1'b1, 1'b0, 32'h0); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'hC || hwdata !== 32'h33) begin errors++; $display("FAIL b2b_c4: htrans %0h haddr %0h hwdata %0h exp 2 c 33", htrans, haddr, hwdata); end
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h44) begin errors++; $display("FAIL b2b_rsp1: v %0b w %0b d %0h exp 1 0 44", rsp_valid, rsp_write, rsp_rdata); end
        @(negedge clk); slave(1'b1, 1'b0, 32'h0000_00CC); #1;
        checks++; if (htrans !== 2'b00 || rsp_valid !== 1'b1 || rsp_write !== 1'b1) begin errors++; $display("FAIL b2b_rsp2: htrans %0h v %0b w %0b exp 0 1 1", htrans, rsp_valid, rsp_write); end
        @(negedge clk); slave(1'b1, 1'b0, 32'h0); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'hCC) begin errors++; $display("FAIL b2b_rsp3: v %0b w %0b d %0h exp 1 0 cc", rsp_valid, rsp_write, rsp_rdata); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: v %0b busy %0b exp 0 0", rsp_valid, busy); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        cmd(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk); cmd(1'b1, 1'b1, 32'h14, 32'h0000_0055); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h10 || cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_c1: htrans %0h haddr %0h ready %0b exp 2 10 1", htrans, haddr, cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); cmd(1'b1, 1'b1, 32'h18, 32'h0000_0066); slave(1'b0, 1'b0, 32'h0); #1;
            checks++; if (cmd_ready !== 1'b0 || htrans !== 2'b10 || haddr !== 32'h14 || hwrite !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: ready %0b htrans %0h haddr %0h hwrite %0b exp 0 2 14 1", i, cmd_ready, htrans, haddr, hwrite); end
        end
        @(negedge clk); cmd(1'b0, 1'b0, 32'h0, 32'h0); slave(1'b1, 1'b0, 32'h0000_1010); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h14 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release: htrans %0h haddr %0h v %0b exp 2 14 0", htrans, haddr, rsp_valid); end
        @(negedge clk); slave(1'b1, 1'b0, 32'h0); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h1010 || hwdata !== 32'h55) begin errors++; $display("FAIL stall_rsp0: v %0b w %0b d %0h hwdata %0h exp 1 0 1010 55", rsp_valid, rsp_write, rsp_rdata, hwdata); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || htrans !== 2'b00) begin errors++; $display("FAIL stall_rsp1: v %0b w %0b htrans %0h exp 1 1 0", rsp_valid, rsp_write, htrans); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_third_cmd: busy %0b v %0b exp 0 0", busy, rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_error();
        cmd(1'b1, 1'b1, 32'h30, 32'h0000_00E0);
        @(negedge clk); cmd(1'b1, 1'b0, 32'h34, 32'h0); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h30) begin errors++; $display("FAIL err_c1: htrans %0h haddr %0h exp 2 30", htrans, haddr); end
        @(negedge clk); cmd(1'b0, 1'b0, 32'h0, 32'h0); slave(1'b0, 1'b1, 32'h0); #1;
        checks++; if (htrans !== 2'b00 || cmd_ready !== 1'b0 || haddr !== 32'h34) begin errors++; $display("FAIL err_first: htrans %0h ready %0b haddr %0h exp 0 0 34", htrans, cmd_ready, haddr); end
        @(negedge clk); slave(1'b1, 1'b1, 32'h0); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h34 || hwrite !== 1'b0) begin errors++; $display("FAIL err_reissue: htrans %0h haddr %0h hwrite %0b exp 2 34 0", htrans, haddr, hwrite); end
        @(negedge clk); slave(1'b1, 1'b0, 32'h0000_3434); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL err_rsp: v %0b w %0b e %0b exp 1 1 1", rsp_valid, rsp_write, rsp_err); end
        @(negedge clk); slave(1'b1, 1'b0, 32'h0); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h3434) begin errors++; $display("FAIL err_next_rsp: v %0b w %0b e %0b d %0h exp 1 0 0 3434", rsp_valid, rsp_write, rsp_err, rsp_rdata); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy: got %0b exp 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cmd(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk); cmd(1'b0, 1'b0, 32'h0, 32'h0); #1;
        checks++; if (htrans !== 2'b10 || haddr !== 32'h40) begin errors++; $display("FAIL rmid_addr: htrans %0h haddr %0h exp 2 40", htrans, haddr); end
        @(negedge clk); slave(1'b0, 1'b0, 32'h0); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %0b exp 1", busy); end
        #1 rstn = 1'b0; #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || htrans !== 2'b00 || haddr !== 32'h0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rmid_async: busy %0b ready %0b htrans %0h haddr %0h d %0h exp 0 1 0 0 0", busy, cmd_ready, htrans, haddr, rsp_rdata); end
        @(negedge clk); rstn = 1'b1; slave(1'b1, 1'b0, 32'h0000_9999);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp%0d: got %0b exp 0", i, rsp_valid); end
            @(negedge clk);
        end
        slave(1'b1, 1'b0, 32'h0);
        do_single_write(32'h0000_0050, 32'h1234_5678);
    endtask

    initial begin
        rstn = 1'b0;
        cmd(1'b0, 1'b0, 32'h0, 32'h0);
        slave(1'b1, 1'b0, 32'h0);
        @(negedge clk); @(negedge clk);
        test_reset();
        @(negedge clk); rstn = 1'b1;
        test_reset();
        @(negedge clk);
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_stall();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
